flash_boot_loader: RTL and testbench

- Boot-time copier that fills the 8 kB boot RAM window at 0xFE000 before the CPU runs.
- Reads the BIOS image from the board SPI flash with a single continuous READ (0x03) burst.
- Packs bytes little-endian into 16-bit words and writes them as a Wishbone master into the boot RAM.
- Holds the CPU in reset until the copy completes; afterwards it is inert and releases the bus.

---
 rtl/flash_boot_loader.sv | 143 ++++++++++++++
 tb/tb_flash_boot_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/flash_boot_loader.sv
// Boot-time copier: reads a BIOS image from SPI flash with one READ burst and
// writes it as little-endian 16-bit words into boot RAM over Wishbone.
module flash_boot_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h0B0000,
  parameter logic [18:0] DEST_BASE  = 19'h7F000,
  parameter int          WORDS      = 4096,
  parameter int          CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        spi_sck_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic [15:0] wb_dat_o,
  output logic [18:0] wb_adr_o,
  output logic        wb_we_o,
  output logic        wb_tga_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic        done_o,
  output logic        cpu_rst_o
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_RD_LO = 3'd2;
  localparam logic [2:0] S_RD_HI = 3'd3;
  localparam logic [2:0] S_WB_WR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
  localparam logic [DW-1:0] DIV_TOP   = DW'(CLK_DIV - 1);
  localparam logic [31:0]   CMD_WORD  = {8'h03, FLASH_ADDR};

  logic [2:0]    r_state;
  logic [DW-1:0] r_div;
  logic [4:0]    r_bit;
  logic [31:0]   r_cmd;
  logic [7:0]    r_shift;
  logic [7:0]    r_lo;
  logic [CW-1:0] r_count;

  wire w_shifting = (r_state == S_CMD) || (r_state == S_RD_LO) || (r_state == S_RD_HI);
  wire w_tick     = (r_div == DIV_TOP);
  wire w_rise     = w_shifting && w_tick && !spi_sck_o;
  wire w_fall     = w_shifting && w_tick && spi_sck_o;
  wire w_last_bit = (r_state == S_CMD) ? (r_bit == 5'd31) : (r_bit == 5'd7);

  assign wb_tga_o = 1'b0;

  // SCK stays frozen outside the shifting states, so Wishbone stalls never lose bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= 5'd0;
      r_cmd      <= 32'd0;
      r_shift    <= 8'd0;
      r_lo       <= 8'd0;
      r_count    <= '0;
      spi_sck_o  <= 1'b0;
      spi_cs_n_o <= 1'b1;
      spi_mosi_o <= 1'b0;
      wb_dat_o   <= 16'd0;
      wb_adr_o   <= 19'd0;
      wb_we_o    <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_sel_o   <= 2'b00;
      done_o     <= 1'b0;
      cpu_rst_o  <= 1'b1;
    end else begin
      if (w_shifting) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) spi_sck_o <= ~spi_sck_o;
        if (w_rise) r_shift <= {r_shift[6:0], spi_miso_i};
        if (w_fall) r_bit <= w_last_bit ? 5'd0 : r_bit + 5'd1;
      end
      case (r_state)
        S_IDLE: begin
          r_state    <= S_CMD;
          spi_cs_n_o <= 1'b0;
          spi_mosi_o <= CMD_WORD[31];
          r_cmd      <= {CMD_WORD[30:0], 1'b0};
          r_bit      <= 5'd0;
          r_div      <= '0;
        end
        S_CMD: begin
          if (w_fall) begin
            spi_mosi_o <= w_last_bit ? 1'b0 : r_cmd[31];
            r_cmd      <= {r_cmd[30:0], 1'b0};
            if (w_last_bit) r_state <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          if (w_fall && w_last_bit) begin
            r_lo    <= r_shift;
            r_state <= S_RD_HI;
          end
        end
        S_RD_HI: begin
          if (w_fall && w_last_bit) begin
            r_state  <= S_WB_WR;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_sel_o <= 2'b11;
            wb_adr_o <= DEST_BASE + 19'(r_count);
            wb_dat_o <= {r_shift, r_lo};
          end
        end
        S_WB_WR: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 2'b00;
            if (r_count == LAST_WORD) begin
              r_state    <= S_DONE;
              spi_cs_n_o <= 1'b1;
              done_o     <= 1'b1;
              cpu_rst_o  <= 1'b0;
              wb_adr_o   <= 19'd0;
              wb_dat_o   <= 16'd0;
            end else begin
              r_count <= r_count + 1'b1;
              r_state <= S_RD_LO;
            end
          end
        end
        S_DONE: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader with a small image (4 words, SCK divider 2),
// a mode-0 SPI flash model and a hand-driven Wishbone slave.
module tb_flash_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sck_o, spi_cs_n_o, spi_mosi_o;
  logic        model_miso = 1'b0;
  logic        junk_miso  = 1'b0;
  logic        junk_mode  = 1'b0;
  logic [15:0] wb_dat_o;
  logic [18:0] wb_adr_o;
  logic        wb_we_o, wb_tga_o, wb_stb_o, wb_cyc_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic        done_o, cpu_rst_o;
  wire         w_miso = junk_mode ? junk_miso : model_miso;

  int checks = 0;
  int failures = 0;
  int rises = 0;
  int sck_total = 0;
  int cs_falls = 0;
  int cyc_cycles = 0;
  int acks = 0;
  int mdl_n = 0;
  logic [7:0]  mdl_b = 8'd0;
  logic [31:0] cmd_cap = 32'd0;

  flash_boot_loader #(
    .FLASH_ADDR(24'h0B0000), .DEST_BASE(19'h7F000), .WORDS(4), .CLK_DIV(2)
  ) dut (
    .clk(clk), .rst(rst),
    .spi_sck_o(spi_sck_o), .spi_cs_n_o(spi_cs_n_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(w_miso),
    .wb_dat_o(wb_dat_o), .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i),
    .done_o(done_o), .cpu_rst_o(cpu_rst_o)
  );

  always #5 clk = ~clk;

  // Flash image: byte k is 0x11*(k+1), i.e. 0x11, 0x22, ... 0x88.
  function automatic logic [7:0] fb(input int k);
    logic [31:0] v;
    v = 32'h11 * (k + 1);
    fb = (k < 8) ? v[7:0] : 8'h00;
  endfunction

  // Flash command capture; the bit count restarts whenever chip select goes high.
  always @(posedge spi_sck_o or posedge spi_cs_n_o) begin
    if (spi_cs_n_o) rises = 0;
    else begin
      if (rises < 32) cmd_cap = {cmd_cap[30:0], spi_mosi_o};
      rises = rises + 1;
    end
  end

  // Data bits are presented MSB-first on the falling SCK edge after the command.
  always @(negedge spi_sck_o) begin
    if (rises >= 32) begin
      mdl_n = rises - 32;
      mdl_b = fb(mdl_n / 8);
      model_miso = mdl_b[7 - (mdl_n % 8)];
    end
  end

  always @(posedge spi_sck_o) sck_total = sck_total + 1;
  always @(negedge spi_cs_n_o) cs_falls = cs_falls + 1;
  always @(posedge clk) if (wb_cyc_o) cyc_cycles = cyc_cycles + 1;
  always @(posedge clk) if (wb_cyc_o && wb_stb_o && wb_ack_i) acks = acks + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, spi_cs_n_o, 1'b1);
    chk({tag, "_sck"}, spi_sck_o, 1'b0);
    chk({tag, "_mosi"}, spi_mosi_o, 1'b0);
    chk({tag, "_cyc_stb_we"}, {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    chk({tag, "_dat"}, wb_dat_o, 16'h0000);
    chk({tag, "_adr"}, wb_adr_o, 19'h00000);
    chk({tag, "_sel_tga"}, {wb_sel_o, wb_tga_o}, 3'b000);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_cpu_rst"}, cpu_rst_o, 1'b1);
  endtask

  // Waits for the write of word w, checks it, stalls dly cycles, then acks once.
  task automatic wb_serve(input int w, input int dly);
    int n;
    int s;
    n = 0;
    while (wb_stb_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("stb_wait_w%0d", w), (n < 2000), 1'b1);
    chk($sformatf("adr_w%0d", w), wb_adr_o, 19'h7F000 + 19'(w));
    chk($sformatf("dat_w%0d", w), wb_dat_o, {fb(2 * w + 1), fb(2 * w)});
    chk($sformatf("ctl_w%0d", w), {wb_cyc_o, wb_we_o, wb_sel_o, wb_tga_o}, 5'b11110);
    s = sck_total;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk($sformatf("stall_stb_w%0d", w), {wb_cyc_o, wb_stb_o, spi_sck_o}, 3'b110);
    end
    chk($sformatf("stall_sck_frozen_w%0d", w), sck_total, s);
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk($sformatf("stb_drop_w%0d", w), {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
  endtask

  initial begin
    int s_sck, s_cs, s_cyc, s_ack;
    int dly[4];
    dly[0] = 0; dly[1] = 1; dly[2] = 7; dly[3] = 0;

    // Reset held for 5 cycles
    repeat (5) @(negedge clk);
    chk_reset_outputs("rst");
    s_sck = sck_total;
    rst = 1'b1;
    @(negedge clk);
    chk("cs_fall_after_release", spi_cs_n_o, 1'b0);
    chk("cs_fall_sck_low", spi_sck_o, 1'b0);

    // First copy with ack stalls of 0, 1, 7, 0 cycles
    wb_serve(0, dly[0]);
    chk("cmd_bits", cmd_cap, 32'h030B0000);
    chk("rises_to_word0", sck_total - s_sck, 48);
    for (int w = 1; w < 4; w++) wb_serve(w, dly[w]);
    chk("rises_total", sck_total - s_sck, 96);
    repeat (3) @(negedge clk);
    chk("done", {done_o, cpu_rst_o, spi_cs_n_o}, 3'b101);
    chk("done_wb_idle", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 5'b00000);
    chk("done_wb_bus", {wb_adr_o, wb_dat_o}, 35'd0);
    chk("acks_first_copy", acks, 4);
    chk("cs_falls_first_copy", cs_falls, 1);

    // Noise after completion must not restart anything
    s_sck = sck_total; s_cs = cs_falls; s_cyc = cyc_cycles; s_ack = acks;
    junk_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wb_ack_i  = 1'($urandom_range(0, 1));
      junk_miso = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    junk_mode = 1'b0;
    chk("after_done_sck", sck_total, s_sck);
    chk("after_done_cs", cs_falls, s_cs);
    chk("after_done_cyc", cyc_cycles, s_cyc);
    chk("after_done_acks", acks, s_ack);
    chk("after_done_sticky", {done_o, cpu_rst_o, spi_cs_n_o}, 3'b101);

    // Second copy, interrupted by reset during word 2
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst2");
    rst = 1'b1;
    wb_serve(0, 0);
    wb_serve(1, 0);
    repeat (20) @(negedge clk);
    chk("mid_copy_active", {spi_cs_n_o, cpu_rst_o}, 2'b01);
    s_ack = acks;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    chk("rst_mid_no_ack", acks, s_ack);
    @(negedge clk);
    chk("rst_mid_ack_held", acks, s_ack);

    // Restart: fresh command and rewrite from word 0
    s_sck = sck_total; s_cs = cs_falls;
    rst = 1'b1;
    wb_serve(0, 0);
    chk("restart_cmd", cmd_cap, 32'h030B0000);
    chk("restart_rises", sck_total - s_sck, 48);
    chk("restart_cs_fall", cs_falls - s_cs, 1);
    for (int w = 1; w < 4; w++) wb_serve(w, 0);
    repeat (3) @(negedge clk);
    chk("restart_done", {done_o, cpu_rst_o, spi_cs_n_o}, 3'b101);
    chk("restart_total_acks", acks, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
